// File: rtl/game_pkg.sv
// Shared game constants and helpers used by the player, shot and RGB blocks.
package game_pkg;

    localparam int COORD_W    = 10;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int SHOT_W_DEF = 4;
    localparam int SHOT_H_DEF = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COORD_W:0]   coord_wide_t;

    // One extra bit keeps base+len from wrapping for sprites near the top of the range.
    function automatic logic in_span(input coord_t base, input coord_t q, input int len);
        coord_wide_t b;
        coord_wide_t p;
        b = {1'b0, base};
        p = {1'b0, q};
        return (p >= b) && (p < b + coord_wide_t'(len));
    endfunction

endpackage

// File: rtl/shot_manager_if.sv
// Control/query/status bundle between the game logic and the shot engine.
interface shot_manager_if #(
    parameter int NUM_SHOTS = 4
);
    logic                                   tick;
    logic                                   gameover;
    logic                                   fire;
    logic [game_pkg::COORD_W-1:0]           reimux;
    logic [game_pkg::COORD_W-1:0]           reimuy;
    logic [NUM_SHOTS-1:0]                   kill;
    logic [game_pkg::COORD_W-1:0]           hc;
    logic [game_pkg::COORD_W-1:0]           vc;
    logic [NUM_SHOTS-1:0]                   shot_valid;
    logic [game_pkg::COORD_W*NUM_SHOTS-1:0] shot_x;
    logic [game_pkg::COORD_W*NUM_SHOTS-1:0] shot_y;
    logic                                   shot_pixel;

    modport master (
        output tick, gameover, fire, reimux, reimuy, kill, hc, vc,
        input  shot_valid, shot_x, shot_y, shot_pixel
    );

    modport slave (
        input  tick, gameover, fire, reimux, reimuy, kill, hc, vc,
        output shot_valid, shot_x, shot_y, shot_pixel
    );
endinterface

// File: rtl/shot_manager_slot.sv
// One shot slot: valid/x/y state, upward motion and its own sprite hit test.
module shot_slot
    import game_pkg::*;
#(
    parameter int SHOT_SPEED = 4,
    parameter int SHOT_W     = SHOT_W_DEF,
    parameter int SHOT_H     = SHOT_H_DEF
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   spawn_i,
    input  logic   kill_i,
    input  logic   move_i,
    input  logic   clear_i,
    input  coord_t spawn_x_i,
    input  coord_t spawn_y_i,
    input  coord_t hc_i,
    input  coord_t vc_i,
    output logic   valid_o,
    output coord_t x_o,
    output coord_t y_o,
    output logic   hit_o
);

    logic   valid_q, valid_d;
    coord_t x_q, x_d;
    coord_t y_q, y_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        if (clear_i) begin
            valid_d = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end else if (spawn_i) begin
            valid_d = 1'b1;
            x_d     = spawn_x_i;
            y_d     = spawn_y_i;
        end else if (move_i && valid_q) begin
            // Leaving the top retires the shot instead of wrapping y.
            if (y_q < coord_t'(SHOT_SPEED)) valid_d = 1'b0;
            else                            y_d     = y_q - coord_t'(SHOT_SPEED);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so all slots update from pre-edge values.
        if (!rst) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign y_o     = y_q;
    assign hit_o   = valid_q && in_span(x_q, hc_i, SHOT_W) && in_span(y_q, vc_i, SHOT_H);

endmodule

// File: rtl/shot_manager.sv
// Player-shot engine: fire cooldown, lowest-free-slot allocation and registered pixel query.
module shot_manager
    import game_pkg::*;
#(
    parameter int NUM_SHOTS  = 4,
    parameter int SHOT_SPEED = 4,
    parameter int COOLDOWN   = 8,
    parameter int SHOT_W     = SHOT_W_DEF,
    parameter int SHOT_H     = SHOT_H_DEF
) (
    input logic           clk,
    input logic           rst,
    shot_manager_if.slave bus
);

    localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    logic [NUM_SHOTS-1:0] valid;
    logic [NUM_SHOTS-1:0] hit;
    logic [NUM_SHOTS-1:0] cand;
    logic [NUM_SHOTS-1:0] spawn_sel;
    logic                 do_spawn;
    logic [CNT_W-1:0]     cool_q, cool_d;
    logic                 pixel_q;

    // Free slots come from pre-edge valid, so a slot retired this cycle waits for the next tick.
    assign cand      = ~valid & ~bus.kill;
    assign do_spawn  = bus.tick & bus.fire & (cool_q == '0) & ~bus.gameover & (|cand);
    assign spawn_sel = do_spawn ? (cand & (~cand + NUM_SHOTS'(1))) : '0;

    always_comb begin
        cool_d = cool_q;
        if (bus.gameover)                  cool_d = '0;
        else if (do_spawn)                 cool_d = CNT_W'(COOLDOWN);
        else if (bus.tick && cool_q != '0) cool_d = cool_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cool_q  <= '0;
            pixel_q <= 1'b0;
        end else begin
            cool_q  <= cool_d;
            pixel_q <= |hit;
        end
    end

    for (genvar i = 0; i < NUM_SHOTS; i++) begin : g_slot
        shot_slot #(
            .SHOT_SPEED (SHOT_SPEED),
            .SHOT_W     (SHOT_W),
            .SHOT_H     (SHOT_H)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .spawn_i   (spawn_sel[i]),
            .kill_i    (bus.kill[i]),
            .move_i    (bus.tick),
            .clear_i   (bus.gameover),
            .spawn_x_i (bus.reimux),
            .spawn_y_i (bus.reimuy),
            .hc_i      (bus.hc),
            .vc_i      (bus.vc),
            .valid_o   (valid[i]),
            .x_o       (bus.shot_x[COORD_W*i +: COORD_W]),
            .y_o       (bus.shot_y[COORD_W*i +: COORD_W]),
            .hit_o     (hit[i])
        );
    end

    assign bus.shot_valid = valid;
    assign bus.shot_pixel = pixel_q;

endmodule
